// File: rtl/sca_pkg.sv
// ============================================================================
// Module      : sca_pkg
// Description : Shared types and constants for the sca_demux 1-to-2 demux.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sca_pkg;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    localparam logic DST_A = 1'b0;
    localparam logic DST_B = 1'b1;

    // A one-entry slot may take a new word when it is empty or is being drained.
    function automatic logic slot_can_load(input logic valid, input logic ready);
        return !valid || ready;
    endfunction

endpackage : sca_pkg

`default_nettype wire

// File: rtl/sca_demux_slot.sv
// ============================================================================
// Module      : sca_demux_slot
// Description : One-entry output holding register with valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sca_demux_slot
    import sca_pkg::*;
#(
    parameter int SIZE = 1
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            LOAD,
    input  logic [SIZE-1:0] DIN,
    output logic [SIZE-1:0] X,
    output logic            X_VALID,
    input  logic            X_READY,
    output logic            CAN_LOAD
);

    slot_state_t     state_q, state_d;
    logic [SIZE-1:0] data_q, data_d;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        if (LOAD) begin
            // A load during a drain simply replaces the departing word.
            state_d = SLOT_FULL;
            data_d  = DIN;
        end else if (X_VALID && X_READY) begin
            state_d = SLOT_EMPTY;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= SLOT_EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    assign X        = data_q;
    assign X_VALID  = (state_q == SLOT_FULL);
    assign CAN_LOAD = slot_can_load(X_VALID, X_READY);

endmodule : sca_demux_slot

`default_nettype wire

// File: rtl/sca_demux.sv
// ============================================================================
// Module      : sca_demux
// Description : Registered 1-to-2 demultiplexer with independent output slots.
//               Optional per-output transfer counters under SCA_DEMUX_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sca_demux
    import sca_pkg::*;
#(
    parameter int SIZE  = 1,
    parameter int CNT_W = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [SIZE-1:0]  IN,
    input  logic             SEL,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic [SIZE-1:0]  A,
    output logic             A_VALID,
    input  logic             A_READY,
    output logic [SIZE-1:0]  B,
    output logic             B_VALID,
    input  logic             B_READY
`ifdef SCA_DEMUX_CNT_EN
    ,
    output logic [CNT_W-1:0] CNT_A,
    output logic [CNT_W-1:0] CNT_B
`endif
);

    logic can_load_a;
    logic can_load_b;
    logic accept;
    logic load_a;
    logic load_b;

    // Readiness depends only on the selected slot, never on IN_VALID.
    assign IN_READY = (SEL == DST_B) ? can_load_b : can_load_a;
    assign accept   = IN_VALID && IN_READY;
    assign load_a   = accept && (SEL == DST_A);
    assign load_b   = accept && (SEL == DST_B);

    sca_demux_slot #(
        .SIZE (SIZE)
    ) u_slot_a (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .LOAD     (load_a),
        .DIN      (IN),
        .X        (A),
        .X_VALID  (A_VALID),
        .X_READY  (A_READY),
        .CAN_LOAD (can_load_a)
    );

    sca_demux_slot #(
        .SIZE (SIZE)
    ) u_slot_b (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .LOAD     (load_b),
        .DIN      (IN),
        .X        (B),
        .X_VALID  (B_VALID),
        .X_READY  (B_READY),
        .CAN_LOAD (can_load_b)
    );

`ifdef SCA_DEMUX_CNT_EN
    logic [CNT_W-1:0] cnt_a_q, cnt_a_d;
    logic [CNT_W-1:0] cnt_b_q, cnt_b_d;

    always_comb begin
        cnt_a_d = cnt_a_q;
        cnt_b_d = cnt_b_q;
        if (load_a) begin
            cnt_a_d = cnt_a_q + CNT_W'(1);
        end
        if (load_b) begin
            cnt_b_d = cnt_b_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            cnt_a_q <= '0;
            cnt_b_q <= '0;
        end else begin
            cnt_a_q <= cnt_a_d;
            cnt_b_q <= cnt_b_d;
        end
    end

    assign CNT_A = cnt_a_q;
    assign CNT_B = cnt_b_q;
`else
    // CNT_W only sizes the transfer counters, which this build omits.
    if (CNT_W < 1) begin : g_cnt_w_unused
    end
`endif

endmodule : sca_demux

`default_nettype wire

// File: tb/tb_sca_demux.sv
// ============================================================================
// Module      : tb_sca_demux
// Description : Directed + constrained-random bench for sca_demux with a
//               queue scoreboard; counter checks follow SCA_DEMUX_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sca_demux;

    localparam int SIZE  = 8;
    localparam int CNT_W = 4;

    logic             CLK;
    logic             RST_N;
    logic [SIZE-1:0]  IN;
    logic             SEL;
    logic             IN_VALID;
    logic             IN_READY;
    logic [SIZE-1:0]  A;
    logic             A_VALID;
    logic             A_READY;
    logic [SIZE-1:0]  B;
    logic             B_VALID;
    logic             B_READY;
`ifdef SCA_DEMUX_CNT_EN
    logic [CNT_W-1:0] CNT_A;
    logic [CNT_W-1:0] CNT_B;
`endif

    sca_demux #(
        .SIZE  (SIZE),
        .CNT_W (CNT_W)
    ) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .IN       (IN),
        .SEL      (SEL),
        .IN_VALID (IN_VALID),
        .IN_READY (IN_READY),
        .A        (A),
        .A_VALID  (A_VALID),
        .A_READY  (A_READY),
        .B        (B),
        .B_VALID  (B_VALID),
        .B_READY  (B_READY)
`ifdef SCA_DEMUX_CNT_EN
        ,
        .CNT_A    (CNT_A),
        .CNT_B    (CNT_B)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int vectors;
    int miscompares;

    // Reference model of both slots.
    logic            known;
    logic            m_va, m_vb;
    logic [SIZE-1:0] m_da, m_db;
    logic [CNT_W-1:0] m_ca, m_cb;
    logic            m_last_rdy;
    logic [SIZE-1:0] qa[$];
    logic [SIZE-1:0] qb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drain_chk(input string tag, input logic [SIZE-1:0] obs, inout logic [SIZE-1:0] q[$]);
        logic [SIZE-1:0] exp;
        if (q.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected no pending word", tag, obs);
        end else begin
            exp = q.pop_front();
            chk(tag, 32'(obs), 32'(exp));
        end
    endtask

    task automatic cycle(input logic rst, input logic iv, input logic sel,
                         input logic [SIZE-1:0] din, input logic ar, input logic br);
        logic exp_rdy;
        logic drain_a, drain_b, acc;
        @(negedge CLK);
        RST_N    = rst;
        IN_VALID = iv;
        SEL      = sel;
        IN       = din;
        A_READY  = ar;
        B_READY  = br;
        #1;
        exp_rdy    = sel ? (!m_vb || br) : (!m_va || ar);
        m_last_rdy = exp_rdy;
        if (known) begin
            chk("in_ready", 32'(IN_READY), 32'(exp_rdy));
            chk("a_valid",  32'(A_VALID),  32'(m_va));
            chk("b_valid",  32'(B_VALID),  32'(m_vb));
            chk("a_data",   32'(A),        32'(m_da));
            chk("b_data",   32'(B),        32'(m_db));
`ifdef SCA_DEMUX_CNT_EN
            chk("cnt_a",    32'(CNT_A),    32'(m_ca));
            chk("cnt_b",    32'(CNT_B),    32'(m_cb));
`endif
            if (rst && m_va && ar) drain_chk("a_drain", A, qa);
            if (rst && m_vb && br) drain_chk("b_drain", B, qb);
        end
        if (!rst) begin
            m_va = 1'b0; m_vb = 1'b0;
            m_da = '0;   m_db = '0;
            m_ca = '0;   m_cb = '0;
            qa.delete(); qb.delete();
            known = 1'b1;
        end else begin
            drain_a = m_va && ar;
            drain_b = m_vb && br;
            acc     = iv && exp_rdy;
            if (acc && !sel) begin
                m_va = 1'b1; m_da = din; qa.push_back(din); m_ca = m_ca + 1'b1;
            end else if (drain_a) begin
                m_va = 1'b0;
            end
            if (acc && sel) begin
                m_vb = 1'b1; m_db = din; qb.push_back(din); m_cb = m_cb + 1'b1;
            end else if (drain_b) begin
                m_vb = 1'b0;
            end
        end
    endtask

    initial begin
        logic            r_iv, r_sel;
        logic [SIZE-1:0] r_din;
        vectors     = 0;
        miscompares = 0;
        known       = 1'b0;
        m_va = 1'b0; m_vb = 1'b0; m_da = '0; m_db = '0; m_ca = '0; m_cb = '0;
        m_last_rdy  = 1'b0;
        RST_N = 1'b0; IN = '0; SEL = 1'b0; IN_VALID = 1'b0; A_READY = 1'b0; B_READY = 1'b0;

        // Reset held two cycles with a valid word presented.
        cycle(1'b0, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 8'hEE, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

        // Single word to A, held while A_READY is low.
        cycle(1'b1, 1'b1, 1'b0, 8'h5A, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

        // Back-pressure on A, then route around it to B.
        cycle(1'b1, 1'b1, 1'b0, 8'h77, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 8'h77, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 8'hC3, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

        // Streaming 16 words to A from a fresh counter; CNT_A wraps to 0.
        cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 1; i <= 16; i++) begin
            cycle(1'b1, 1'b1, 1'b0, 8'(i), 1'b1, 1'b0);
        end
        cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

        // Alternating destinations with both outputs ready.
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 1'b1, i[0], 8'(8'h80 + i), 1'b1, 1'b1);
        end
        cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

        // Random traffic; upstream holds its word while stalled.
        r_iv = 1'b0; r_sel = 1'b0; r_din = '0;
        for (int i = 0; i < 80; i++) begin
            if (!(r_iv && !m_last_rdy)) begin
                r_iv  = 1'($urandom_range(0, 3) != 0);
                r_sel = 1'($urandom_range(0, 1));
                r_din = 8'($urandom_range(0, 255));
            end
            cycle(1'b1, r_iv, r_sel, r_din,
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) != 0));
        end
        cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

        // Both slots full, accept pending, then reset: nothing delivered.
        cycle(1'b1, 1'b1, 1'b0, 8'hAA, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 8'hBB, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 8'hCC, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_sca_demux

`default_nettype wire
